// File: rtl/modport_regfile.sv
// modport_regfile: 32-entry register file with a registered read port and
// a registered adder. x0 is hardwired to zero and ignores writes.
//
// Parameters:
//   BUS_WIDTH  - register, operand and result width
//   ADDR_WIDTH - packed address bus, three equal fields {rs1, rs2, rd}
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   rs_addr_valid  - rs1_rs2_rd is valid this cycle
//   rs1_rs2_rd     - packed {rs1, rs2, rd} addresses
//   rs_store       - store access: rs2 on rs_data, imme_data as ALU operand B
//   imme_data      - immediate operand
//   rd_wr_en       - write-back strobe into x[rd_latch]
//   rs_data_mux    - write-back data
//   op_done        - ends the operation, clears rd_latch
//   rs_data        - registered read data
//   alu_data_out   - registered ALU sum
//   alu_data_valid - one-cycle pulse after each accepted address
// Build option:
//   REGFILE_BYPASS_EN - forward rs_data_mux to a same-edge read of rd_latch
module modport_regfile #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rs_addr_valid,
    input  logic [ADDR_WIDTH-1:0] rs1_rs2_rd,
    input  logic                  rs_store,
    input  logic [BUS_WIDTH-1:0]  imme_data,
    input  logic                  rd_wr_en,
    input  logic [BUS_WIDTH-1:0]  rs_data_mux,
    input  logic                  op_done,
    output logic [BUS_WIDTH-1:0]  rs_data,
    output logic [BUS_WIDTH-1:0]  alu_data_out,
    output logic                  alu_data_valid
);

    localparam int AW   = ADDR_WIDTH / 3;
    localparam int NREG = 1 << AW;

    logic [AW-1:0] rs1_a;
    logic [AW-1:0] rs2_a;
    logic [AW-1:0] rd_a;

    assign rs1_a = rs1_rs2_rd[3*AW-1:2*AW];
    assign rs2_a = rs1_rs2_rd[2*AW-1:AW];
    assign rd_a  = rs1_rs2_rd[AW-1:0];

    logic [BUS_WIDTH-1:0] rf_q [NREG];
    logic [AW-1:0]        rd_latch_q, rd_latch_d;
    logic [BUS_WIDTH-1:0] rs_data_q, rs_data_d;
    logic [BUS_WIDTH-1:0] alu_q, alu_d;
    logic                 valid_q;

    logic [BUS_WIDTH-1:0] rs1_v;
    logic [BUS_WIDTH-1:0] rs2_v;
    logic                 wr_en_eff;

    // A latched rd of zero means "no destination": the write is dropped.
    assign wr_en_eff = rd_wr_en && (rd_latch_q != '0);

    always_comb begin
        rs1_v = (rs1_a == '0) ? '0 : rf_q[rs1_a];
        rs2_v = (rs2_a == '0) ? '0 : rf_q[rs2_a];
`ifdef REGFILE_BYPASS_EN
        // wr_en_eff implies rd_latch_q != 0, so x0 is never forwarded.
        if (wr_en_eff && (rs1_a == rd_latch_q)) begin
            rs1_v = rs_data_mux;
        end
        if (wr_en_eff && (rs2_a == rd_latch_q)) begin
            rs2_v = rs_data_mux;
        end
`endif
    end

    always_comb begin
        rd_latch_d = rd_latch_q;
        rs_data_d  = rs_data_q;
        alu_d      = alu_q;
        if (op_done) begin
            rd_latch_d = '0;
        end
        // A new address wins over op_done on the same edge.
        if (rs_addr_valid) begin
            rd_latch_d = rd_a;
            rs_data_d  = rs_store ? rs2_v : rs1_v;
            alu_d      = rs1_v + (rs_store ? imme_data : rs2_v);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            rd_latch_q <= '0;
            rs_data_q  <= '0;
            alu_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            // Uses the old rd_latch_q, so write precedes any re-latch/clear.
            if (wr_en_eff) begin
                rf_q[rd_latch_q] <= rs_data_mux;
            end
            rd_latch_q <= rd_latch_d;
            rs_data_q  <= rs_data_d;
            alu_q      <= alu_d;
            valid_q    <= rs_addr_valid;
        end
    end

    assign rs_data        = rs_data_q;
    assign alu_data_out   = alu_q;
    assign alu_data_valid = valid_q;

endmodule

// File: tb/tb_modport_regfile.sv
// tb_modport_regfile: directed-vector bench for modport_regfile.
// Expected values are hand-computed; REGFILE_BYPASS_EN selects conflict result.
module tb_modport_regfile;

    logic        clk;
    logic        rst_n;
    logic        rs_addr_valid;
    logic [14:0] rs1_rs2_rd;
    logic        rs_store;
    logic [31:0] imme_data;
    logic        rd_wr_en;
    logic [31:0] rs_data_mux;
    logic        op_done;
    logic [31:0] rs_data;
    logic [31:0] alu_data_out;
    logic        alu_data_valid;

    int n_run;
    int n_fail;

    modport_regfile #(
        .BUS_WIDTH (32),
        .ADDR_WIDTH(15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs_addr_valid (rs_addr_valid),
        .rs1_rs2_rd    (rs1_rs2_rd),
        .rs_store      (rs_store),
        .imme_data     (imme_data),
        .rd_wr_en      (rd_wr_en),
        .rs_data_mux   (rs_data_mux),
        .op_done       (op_done),
        .rs_data       (rs_data),
        .alu_data_out  (alu_data_out),
        .alu_data_valid(alu_data_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rs_addr_valid = 1'b0;
        rs_store      = 1'b0;
        rd_wr_en      = 1'b0;
        op_done       = 1'b0;
        imme_data     = '0;
        rs_data_mux   = '0;
        rs1_rs2_rd    = '0;
    endtask

    task automatic set_addr(input int r1, input int r2, input int rd,
                            input logic st, input logic [31:0] imm);
        rs_addr_valid = 1'b1;
        rs1_rs2_rd    = {r1[4:0], r2[4:0], rd[4:0]};
        rs_store      = st;
        imme_data     = imm;
    endtask

    task automatic issue(input int r1, input int r2, input int rd,
                         input logic st, input logic [31:0] imm);
        set_addr(r1, r2, rd, st, imm);
        tick();
        idle();
    endtask

    task automatic wr(input logic [31:0] d);
        rd_wr_en    = 1'b1;
        rs_data_mux = d;
        tick();
        idle();
    endtask

    task automatic wr_reg(input int rd, input logic [31:0] d);
        issue(0, 0, rd, 1'b0, '0);
        wr(d);
    endtask

    logic [31:0] conflict_exp;

    initial begin
        n_run  = 0;
        n_fail = 0;
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rs_data", rs_data, 32'h0);
        chk("rst_alu", alu_data_out, 32'h0);
        chk("rst_valid", {31'b0, alu_data_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_valid", {31'b0, alu_data_valid}, 32'h0);

        // write/read
        wr_reg(5, 32'hDEADBEEF);
        issue(5, 0, 0, 1'b0, '0);
        chk("rd5_data", rs_data, 32'hDEADBEEF);
        chk("rd5_alu", alu_data_out, 32'hDEADBEEF);
        chk("rd5_valid", {31'b0, alu_data_valid}, 32'h1);
        tick();
        chk("hold_valid", {31'b0, alu_data_valid}, 32'h0);
        chk("hold_data", rs_data, 32'hDEADBEEF);

        // ALU wrap
        wr_reg(1, 32'hFFFFFFFF);
        wr_reg(2, 32'h2);
        issue(1, 2, 0, 1'b0, '0);
        chk("wrap_alu", alu_data_out, 32'h1);
        chk("wrap_data", rs_data, 32'hFFFFFFFF);
        chk("wrap_valid", {31'b0, alu_data_valid}, 32'h1);
        tick();
        chk("wrap_pulse", {31'b0, alu_data_valid}, 32'h0);

        // store path
        wr_reg(3, 32'h10);
        wr_reg(4, 32'hABCD);
        issue(3, 4, 0, 1'b1, 32'h8);
        chk("st_data", rs_data, 32'hABCD);
        chk("st_alu", alu_data_out, 32'h18);

        // x0 ignores writes
        issue(0, 0, 0, 1'b0, '0);
        wr(32'h55);
        issue(0, 5, 0, 1'b0, '0);
        chk("x0_data", rs_data, 32'h0);
        chk("x0_alu", alu_data_out, 32'hDEADBEEF);

        // op_done drops later write
        wr_reg(7, 32'h11);
        issue(0, 0, 7, 1'b0, '0);
        op_done = 1'b1;
        tick();
        idle();
        wr(32'h66);
        issue(7, 0, 0, 1'b0, '0);
        chk("opdone_x7", rs_data, 32'h11);

        // same-edge read of the register being written
        issue(0, 0, 7, 1'b0, '0);
        set_addr(7, 0, 7, 1'b0, '0);
        rd_wr_en    = 1'b1;
        rs_data_mux = 32'h77;
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        conflict_exp = 32'h77;
`else
        conflict_exp = 32'h11;
`endif
        chk("conf_data", rs_data, conflict_exp);
        chk("conf_alu", alu_data_out, conflict_exp);
        issue(7, 0, 0, 1'b0, '0);
        chk("conf_x7", rs_data, 32'h77);

        // valid + write: old rd written, new rd latched
        issue(0, 0, 9, 1'b0, '0);
        set_addr(0, 0, 10, 1'b0, '0);
        rd_wr_en    = 1'b1;
        rs_data_mux = 32'h99;
        tick();
        idle();
        wr(32'hAA);
        // back-to-back valids
        set_addr(9, 10, 0, 1'b0, '0);
        tick();
        chk("b2b1_alu", alu_data_out, 32'h143);
        chk("b2b1_valid", {31'b0, alu_data_valid}, 32'h1);
        set_addr(10, 9, 0, 1'b1, 32'h1);
        tick();
        idle();
        chk("b2b2_data", rs_data, 32'h99);
        chk("b2b2_alu", alu_data_out, 32'hAB);
        chk("b2b2_valid", {31'b0, alu_data_valid}, 32'h1);

        // write + op_done: write lands, later write dropped
        issue(0, 0, 11, 1'b0, '0);
        rd_wr_en    = 1'b1;
        rs_data_mux = 32'h5;
        op_done     = 1'b1;
        tick();
        idle();
        wr(32'h6);
        issue(11, 0, 0, 1'b0, '0);
        chk("wrdone_x11", rs_data, 32'h5);

        // valid + op_done: new rd wins
        set_addr(0, 0, 12, 1'b0, '0);
        op_done = 1'b1;
        tick();
        idle();
        wr(32'h12);
        issue(12, 0, 0, 1'b0, '0);
        chk("vdone_x12", rs_data, 32'h12);

        // mid-cycle reset
        issue(5, 1, 0, 1'b0, '0);
        chk("pre_rst_alu", alu_data_out, 32'hDEADBEEE);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", rs_data, 32'h0);
        chk("mid_rst_alu", alu_data_out, 32'h0);
        chk("mid_rst_valid", {31'b0, alu_data_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(5, 1, 0, 1'b0, '0);
        chk("post_rst_data", rs_data, 32'h0);
        chk("post_rst_alu", alu_data_out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
